// File: rtl/ysyx_22040759_pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22040759_pc_seq_pkg
// Shared definitions for the program-counter sequencer:
//   - sequencer state encodings (2 bits)
//   - default address width and reset PC
//   - next-PC source codes used by the next-PC selector
//   - saturating increment helper for the optional performance counters
// -----------------------------------------------------------------------------
package ysyx_22040759_pc_seq_pkg;

  localparam int          XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    PCS_REQ  = 2'd0,
    PCS_WAIT = 2'd1,
    PCS_EXEC = 2'd2,
    PCS_HALT = 2'd3
  } pcs_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BLU  = 2'd1,
    NPC_JMP  = 2'd2,
    NPC_TRAP = 2'd3
  } npc_src_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [63:0] sat_inc64(input logic [63:0] value);
    logic [63:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ysyx_22040759_npc_sel.sv
// -----------------------------------------------------------------------------
// ysyx_22040759_npc_sel
// Combinational next-PC selector. Priority: trap vector > jump target >
// branch-unit result > pc+4. Jump/branch targets with bits[1:0] != 0 are
// flagged as misaligned and forced down to a word boundary; trap vectors are
// passed through unchecked.
// Ports:
//   pc          in  current PC
//   blu_pc      in  branch-unit next PC
//   jmp_valid   in  jump redirect request
//   jmp_target  in  jump target
//   trap_valid  in  trap redirect request
//   trap_vec    in  trap vector
//   npc         out selected (aligned) next PC
//   misalign    out selected jump/branch target was not word aligned
// -----------------------------------------------------------------------------
module ysyx_22040759_npc_sel
  import ysyx_22040759_pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] blu_pc,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] npc,
  output logic            misalign
);

  npc_src_e        src;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

  // Sequential fallback; wraps silently at the top of the address space.
  assign pc_inc = pc + {{(XLEN-3){1'b0}}, 3'b100};

  // Priority encode the redirect requests into a source code.
  always_comb begin
    src = NPC_BLU;
    if (trap_valid) begin
      src = NPC_TRAP;
    end else if (jmp_valid) begin
      src = NPC_JMP;
    end else begin
      src = NPC_BLU;
    end
  end

  // Pick the raw target and apply the alignment check to non-trap sources.
  always_comb begin
    target   = pc_inc;
    npc      = pc_inc;
    misalign = 1'b0;
    case (src)
      NPC_TRAP: target = trap_vec;
      NPC_JMP:  target = jmp_target;
      NPC_BLU:  target = blu_pc;
      default:  target = pc_inc;
    endcase
    if ((src != NPC_TRAP) && (target[1:0] != 2'b00)) begin
      misalign = 1'b1;
      npc      = {target[XLEN-1:2], 2'b00};
    end else begin
      misalign = 1'b0;
      npc      = target;
    end
  end

endmodule

// File: rtl/ysyx_22040759_pc_seq.sv
// -----------------------------------------------------------------------------
// ysyx_22040759_pc_seq
// Program-counter sequencer for the multi-cycle core. Owns the PC, fetches
// through a valid/ready handshake with the IFU, holds the returned
// instruction for decode/branch and commits the next PC on exe_done.
// FSM: REQ -> WAIT -> EXEC -> REQ; HALT is terminal until rst.
// Optional feature macro: YSYX_22040759_PC_PERF_EN adds saturating 64-bit
// counters perf_inst / perf_redir / perf_stall.
// Ports:
//   clk, rst                     clock, async active-high reset
//   if_req_valid/ready/addr      fetch request channel (addr = pc)
//   if_rsp_valid/inst/ready      fetch response channel
//   inst_valid, inst, pc_out     held instruction and its PC
//   exe_done                     commit next PC this cycle
//   blu_pc                       branch-unit next PC
//   jmp_valid, jmp_target        jump redirect
//   trap_valid, trap_vec         trap redirect (highest priority)
//   halt                         stop fetching
//   misalign                     1-cycle pulse on misaligned jump/branch commit
//   halted                       sequencer parked in HALT
// -----------------------------------------------------------------------------
module ysyx_22040759_pc_seq
  import ysyx_22040759_pc_seq_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_rsp_valid,
  input  logic [31:0]     if_rsp_inst,
  output logic            if_rsp_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc_out,
  input  logic            exe_done,
  input  logic [XLEN-1:0] blu_pc,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt,
  output logic            misalign,
  output logic            halted
`ifdef YSYX_22040759_PC_PERF_EN
  ,
  output logic [63:0]     perf_inst,
  output logic [63:0]     perf_redir,
  output logic [63:0]     perf_stall
`endif
);

  pcs_state_e      state;
  pcs_state_e      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic            sel_misalign;
  logic            req_fire;
  logic            rsp_fire;
  logic            commit;

  ysyx_22040759_npc_sel #(
    .XLEN(XLEN)
  ) u_npc_sel (
    .pc        (pc),
    .blu_pc    (blu_pc),
    .jmp_valid (jmp_valid),
    .jmp_target(jmp_target),
    .trap_valid(trap_valid),
    .trap_vec  (trap_vec),
    .npc       (npc),
    .misalign  (sel_misalign)
  );

  assign if_req_addr = pc;
  assign pc_out      = pc;

  // The handshake flags are registered copies of the state, so the handshakes
  // use them directly; the REQ flag lags reset release by one cycle.
  assign req_fire = if_req_valid & if_req_ready;
  assign rsp_fire = if_rsp_ready & if_rsp_valid;
  assign commit   = inst_valid & exe_done;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      PCS_REQ: begin
        if (halt) begin
          state_nxt = PCS_HALT;
        end else if (req_fire) begin
          state_nxt = PCS_WAIT;
        end else begin
          state_nxt = PCS_REQ;
        end
      end
      PCS_WAIT: begin
        if (halt) begin
          state_nxt = PCS_HALT;
        end else if (rsp_fire) begin
          state_nxt = PCS_EXEC;
        end else begin
          state_nxt = PCS_WAIT;
        end
      end
      PCS_EXEC: begin
        if (commit) begin
          state_nxt = halt ? PCS_HALT : PCS_REQ;
        end else begin
          state_nxt = PCS_EXEC;
        end
      end
      PCS_HALT: state_nxt = PCS_HALT;
      default:  state_nxt = PCS_REQ;
    endcase
  end

  // State, PC, instruction and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PCS_REQ;
      pc           <= RESET_PC;
      inst         <= 32'h0000_0000;
      if_req_valid <= 1'b0;
      if_rsp_ready <= 1'b0;
      inst_valid   <= 1'b0;
      halted       <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      state        <= state_nxt;
      if_req_valid <= (state_nxt == PCS_REQ);
      if_rsp_ready <= (state_nxt == PCS_WAIT);
      inst_valid   <= (state_nxt == PCS_EXEC);
      halted       <= (state_nxt == PCS_HALT);
      misalign     <= commit & sel_misalign;
      if (commit) begin
        pc <= npc;
      end
      if (rsp_fire) begin
        inst <= if_rsp_inst;
      end
    end
  end

`ifdef YSYX_22040759_PC_PERF_EN
  logic [XLEN-1:0] pc_inc;
  logic            redirect;

  assign pc_inc   = pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign redirect = commit & (npc != pc_inc);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst  <= 64'd0;
      perf_redir <= 64'd0;
      perf_stall <= 64'd0;
    end else begin
      if (commit) begin
        perf_inst <= sat_inc64(perf_inst);
      end
      if (redirect) begin
        perf_redir <= sat_inc64(perf_redir);
      end
      if (state == PCS_WAIT) begin
        perf_stall <= sat_inc64(perf_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040759_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22040759_pc_seq
// Self-checking bench for the PC sequencer: a table of next-PC selection
// vectors, directed multi-cycle sequences (fetch stall, halt, reset during
// WAIT) and randomized instructions checked against a transaction-level
// next-PC model.
// -----------------------------------------------------------------------------
module tb_ysyx_22040759_pc_seq;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        if_rsp_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc_out;
  logic        exe_done;
  logic [63:0] blu_pc;
  logic        jmp_valid;
  logic [63:0] jmp_target;
  logic        trap_valid;
  logic [63:0] trap_vec;
  logic        halt;
  logic        misalign;
  logic        halted;
`ifdef YSYX_22040759_PC_PERF_EN
  logic [63:0] perf_inst;
  logic [63:0] perf_redir;
  logic [63:0] perf_stall;
`endif

  always #5 clk = ~clk;

  ysyx_22040759_pc_seq dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr (if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_inst (if_rsp_inst),
    .if_rsp_ready(if_rsp_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc_out      (pc_out),
    .exe_done    (exe_done),
    .blu_pc      (blu_pc),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .trap_valid  (trap_valid),
    .trap_vec    (trap_vec),
    .halt        (halt),
    .misalign    (misalign),
    .halted      (halted)
`ifdef YSYX_22040759_PC_PERF_EN
    ,
    .perf_inst   (perf_inst),
    .perf_redir  (perf_redir),
    .perf_stall  (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [63:0]     mpc;
  longint unsigned m_inst, m_redir, m_stall;

  typedef struct {
    logic        tv;
    logic [63:0] tvec;
    logic        jv;
    logic [63:0] jt;
    logic [63:0] bp;
    logic [63:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the redirect rules: trap wins, then jump, then branch unit;
  // a misaligned jump/branch target is rounded down to a multiple of 4.
  function automatic logic [63:0] ref_next(input logic tv, input logic [63:0] tvec,
                                           input logic jv, input logic [63:0] jt,
                                           input logic [63:0] bp, output logic mis);
    logic [63:0] t;
    mis = 1'b0;
    if (tv) return tvec;
    t = jv ? jt : bp;
    if ((t % 64'd4) != 64'd0) begin
      mis = 1'b1;
      t   = t - (t % 64'd4);
    end
    return t;
  endfunction

  task automatic garbage();
    trap_valid = 1'($urandom);
    jmp_valid  = 1'($urandom);
    trap_vec   = {$urandom, $urandom};
    jmp_target = {$urandom, $urandom};
    blu_pc     = {$urandom, $urandom};
  endtask

  task automatic quiet();
    trap_valid = 1'b0;
    jmp_valid  = 1'b0;
    exe_done   = 1'b0;
    halt       = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_inst  = 32'h0;
    quiet();
    step();
    step();
    chk("rst_req_valid", if_req_valid, 1'b0);
    chk("rst_rsp_ready", if_rsp_ready, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_addr", if_req_addr, RST_PC);
    rst     = 1'b0;
    mpc     = RST_PC;
    m_inst  = 0;
    m_redir = 0;
    m_stall = 0;
  endtask

  // One full instruction: fetch (optional request stall with a stray
  // response), response after rsp_dly WAIT cycles, EXEC hold, then commit.
  task automatic run_inst(input string tag, input logic tv, input logic [63:0] tvec,
                          input logic jv, input logic [63:0] jt, input logic [63:0] bp,
                          input logic hlt, input int req_dly, input int rsp_dly,
                          input int exe_dly, input logic [63:0] exp_pc, input logic exp_mis);
    int          n;
    logic [31:0] iw;
    if_req_ready = 1'b0;
    n = 0;
    while (!if_req_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_req_valid"}, if_req_valid, 1'b1);
    chk({tag, "_req_addr"}, if_req_addr, mpc);
    for (int i = 0; i < req_dly; i++) begin
      garbage();
      if (i == 2) begin
        if_rsp_valid = 1'b1;
        if_rsp_inst  = 32'hDEAD_BEEF;
      end else begin
        if_rsp_valid = 1'b0;
      end
      step();
      chk({tag, "_stall_valid"}, if_req_valid, 1'b1);
      chk({tag, "_stall_addr"}, if_req_addr, mpc);
      chk({tag, "_stall_no_wait"}, if_rsp_ready, 1'b0);
    end
    if_rsp_valid = 1'b0;
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    chk({tag, "_wait_rsp_ready"}, if_rsp_ready, 1'b1);
    chk({tag, "_wait_req_valid"}, if_req_valid, 1'b0);
    for (int i = 0; i < rsp_dly; i++) begin
      garbage();
      step();
    end
    m_stall += longint'(rsp_dly + 1);
    iw           = $urandom;
    if_rsp_valid = 1'b1;
    if_rsp_inst  = iw;
    step();
    if_rsp_valid = 1'b0;
    chk({tag, "_inst_valid"}, inst_valid, 1'b1);
    chk({tag, "_inst"}, inst, iw);
    chk({tag, "_pc_out"}, pc_out, mpc);
    chk({tag, "_exec_rsp_ready"}, if_rsp_ready, 1'b0);
    for (int i = 0; i < exe_dly; i++) begin
      garbage();
      step();
      chk({tag, "_hold_valid"}, inst_valid, 1'b1);
      chk({tag, "_hold_pc"}, pc_out, mpc);
    end
    trap_valid = tv;
    trap_vec   = tvec;
    jmp_valid  = jv;
    jmp_target = jt;
    blu_pc     = bp;
    halt       = hlt;
    exe_done   = 1'b1;
    step();
    quiet();
    m_inst++;
    if (exp_pc != mpc + 64'd4) m_redir++;
    mpc = exp_pc;
    chk({tag, "_misalign"}, misalign, exp_mis);
    chk({tag, "_inst_valid_drop"}, inst_valid, 1'b0);
    chk({tag, "_halted"}, halted, hlt);
    chk({tag, "_next_req_valid"}, if_req_valid, !hlt);
    chk({tag, "_next_addr"}, if_req_addr, mpc);
    if (exp_mis) begin
      step();
      chk({tag, "_misalign_pulse"}, misalign, 1'b0);
    end
  endtask

`ifdef YSYX_22040759_PC_PERF_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_perf_inst"}, perf_inst, m_inst);
    chk({tag, "_perf_redir"}, perf_redir, m_redir);
    chk({tag, "_perf_stall"}, perf_stall, m_stall);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        tv, jv, mis;
    logic [63:0] tvec, jt, bp, exp;

    vt[0] = '{1'b1, 64'h8000_2000, 1'b1, 64'h8000_1000, 64'h8000_0040, 64'h8000_2000, 1'b0};
    vt[1] = '{1'b0, 64'h8000_2000, 1'b1, 64'h8000_1000, 64'h8000_0040, 64'h8000_1000, 1'b0};
    vt[2] = '{1'b0, 64'h8000_2000, 1'b0, 64'h8000_1000, 64'h8000_0040, 64'h8000_0040, 1'b0};
    vt[3] = '{1'b0, 64'h0,         1'b1, 64'h8000_0006, 64'h8000_0044, 64'h8000_0004, 1'b1};
    vt[4] = '{1'b0, 64'h0,         1'b0, 64'h0,         64'h8000_0043, 64'h8000_0040, 1'b1};
    vt[5] = '{1'b1, 64'h8000_0102, 1'b1, 64'h3,         64'h1,         64'h8000_0102, 1'b0};
    vt[6] = '{1'b0, 64'h0,         1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vt[7] = '{1'b0, 64'h0,         1'b0, 64'h0,         64'h0,         64'h0,         1'b0};

    rst          = 1'b1;
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_inst  = 32'h0;
    blu_pc       = 64'h0;
    jmp_target   = 64'h0;
    trap_vec     = 64'h0;
    quiet();
    do_reset();
`ifdef YSYX_22040759_PC_PERF_EN
    chk_perf("reset");
`endif

    // basic fetch at RESET_PC, sequential commit
    run_inst("t1", 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0004, 1'b0, 0, 0, 0,
             64'h8000_0004, 1'b0);

    // next-PC selection table
    for (int i = 0; i < 8; i++) begin
      run_inst($sformatf("vec%0d", i), vt[i].tv, vt[i].tvec, vt[i].jv, vt[i].jt, vt[i].bp,
               1'b0, 0, i % 3, i % 2, vt[i].exp_pc, vt[i].exp_mis);
    end

    // request held 5 cycles with a stray response dropped in REQ
    run_inst("t3", 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0010, 1'b0, 5, 1, 2,
             64'h8000_0010, 1'b0);

    // randomized instructions against the model
    for (int k = 0; k < 40; k++) begin
      tv   = ($urandom_range(0, 3) == 0);
      jv   = ($urandom_range(0, 2) == 0);
      tvec = {$urandom, $urandom};
      jt   = {$urandom, $urandom};
      bp   = mpc + 64'd4;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) bp = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) bp[1:0] = 2'b00;
      exp = ref_next(tv, tvec, jv, jt, bp, mis);
      run_inst($sformatf("rnd%0d", k), tv, tvec, jv, jt, bp, 1'b0,
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), exp, mis);
    end
`ifdef YSYX_22040759_PC_PERF_EN
    chk_perf("rnd");
`endif

    // reset asserted in WAIT; late IFU response must be dropped
    if_req_ready = 1'b0;
    while (!if_req_valid) step();
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    chk("t6_in_wait", if_rsp_ready, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_addr", if_req_addr, RST_PC);
    chk("t6_async_rsp_ready", if_rsp_ready, 1'b0);
    step();
    rst          = 1'b0;
    mpc          = RST_PC;
    m_inst       = 0;
    m_redir      = 0;
    m_stall      = 0;
    if_rsp_valid = 1'b1;
    if_rsp_inst  = 32'hDEAD_BEEF;
    step();
    if_rsp_valid = 1'b0;
    chk("t6_late_rsp_ready", if_rsp_ready, 1'b0);
    chk("t6_late_inst_valid", inst_valid, 1'b0);
    chk("t6_late_inst", inst, 32'h0);
`ifdef YSYX_22040759_PC_PERF_EN
    chk_perf("t6");
`endif
    run_inst("t6", 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0004, 1'b0, 0, 0, 0,
             64'h8000_0004, 1'b0);

    // halt on commit: PC still updates, no more fetches, reset clears
    run_inst("t5", 1'b0, 64'h0, 1'b1, 64'h8000_0100, 64'h8000_0008, 1'b1, 0, 0, 0,
             64'h8000_0100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if_rsp_valid = 1'b1;
      step();
      chk("t5_no_fetch", if_req_valid, 1'b0);
      chk("t5_halted", halted, 1'b1);
    end
    if_rsp_valid = 1'b0;
`ifdef YSYX_22040759_PC_PERF_EN
    chk_perf("t5");
`endif
    do_reset();
    run_inst("t5_after", 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0004, 1'b0, 0, 0, 0,
             64'h8000_0004, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
